// File: rtl/aemb2_wb_arbiter_if.sv
// Purpose: bundles the per-channel Wishbone master buses and the shared slave bus of the arbiter.
// Latency: none; this file only declares wires.
// Backpressure: the slave's s_ack_i reaches the granted master as m_ack_o; stalled masters hold cyc/stb.
interface aemb2_wb_arbiter_if #(
    parameter int NCH = 3,
    parameter int AWB = 32
);
    // channel side (bit/slice n belongs to channel n)
    logic [NCH-1:0]         m_cyc_i;
    logic [NCH-1:0]         m_stb_i;
    logic [NCH-1:0]         m_wre_i;
    logic [NCH-1:0]         m_tag_i;
    logic [NCH*(AWB-2)-1:0] m_adr_i;
    logic [NCH*32-1:0]      m_dat_i;
    logic [NCH*4-1:0]       m_sel_i;
    logic [31:0]            m_dat_o;
    logic [NCH-1:0]         m_ack_o;
    logic [NCH-1:0]         m_err_o;

    // shared slave side
    logic [AWB-3:0]         s_adr_o;
    logic [31:0]            s_dat_o;
    logic [3:0]             s_sel_o;
    logic                   s_cyc_o;
    logic                   s_stb_o;
    logic                   s_wre_o;
    logic                   s_tag_o;
    logic [31:0]            s_dat_i;
    logic                   s_ack_i;

    // The arbiter is the slave of the channel masters.
    modport slave (
        input  m_cyc_i, m_stb_i, m_wre_i, m_tag_i, m_adr_i, m_dat_i, m_sel_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_wre_o, s_tag_o,
        input  s_dat_i, s_ack_i
    );

    // Environment view: the channel masters plus the downstream slave device.
    modport master (
        output m_cyc_i, m_stb_i, m_wre_i, m_tag_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_wre_o, s_tag_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/aemb2_wb_arbiter.sv
// Purpose: arbitrates AEMB_NCH Wishbone masters onto one slave bus (fixed or round-robin), with stall timeout.
// Latency: 1 cycle request-to-grant; once granted, bus signals and ack pass through combinationally.
// Backpressure: grant held while owner keeps cyc; a stall of 2^AEMB_TMO-1 cycles errors the owner and aborts.
module aemb2_wb_arbiter #(
    parameter int AEMB_NCH = 3,
    parameter int AEMB_AWB = 32,
    parameter int AEMB_ARB = 1,
    parameter int AEMB_TMO = 8
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    aemb2_wb_arbiter_if.slave wb
);
    localparam int GW = (AEMB_NCH > 1) ? $clog2(AEMB_NCH) : 1;
    localparam int AW = AEMB_AWB - 2;
    // Counter value one below all-ones: a further stalled cycle would reach terminal count.
    localparam logic [AEMB_TMO-1:0] TMO_PRE = {{(AEMB_TMO-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

    state_t              state;
    logic [GW-1:0]       gnt;
    logic [GW-1:0]       last;
    logic [AEMB_TMO-1:0] tmo;

    logic [AEMB_NCH-1:0] req;
    logic                win_vld;
    logic [GW-1:0]       win;
    int                  base;
    int                  idx;
    int                  gi;
    logic                own;
    logic                stall;
    logic                tmo_hit;

    assign req = wb.m_cyc_i & wb.m_stb_i;
    assign gi  = int'(gnt);
    assign own = (state == OWN);

    // Search start: channel 0 in fixed mode, one past the last grant in round-robin mode.
    always_comb begin
        base = 0;
        if (AEMB_ARB != 0 && int'(last) != AEMB_NCH - 1) begin
            base = int'(last) + 1;
        end
    end

    // Circular priority search; indices wrap modulo AEMB_NCH so unused gnt codes never win.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        idx     = 0;
        for (int i = 0; i < AEMB_NCH; i++) begin
            idx = base + i;
            if (idx >= AEMB_NCH) begin
                idx = idx - AEMB_NCH;
            end
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = idx[GW-1:0];
            end
        end
    end

    // Slave bus follows the granted channel; cyc/stb are gated so IDLE/ABORT leave the bus quiet.
    always_comb begin
        wb.s_adr_o = wb.m_adr_i[gi*AW +: AW];
        wb.s_dat_o = wb.m_dat_i[gi*32 +: 32];
        wb.s_sel_o = wb.m_sel_i[gi*4 +: 4];
        wb.s_wre_o = wb.m_wre_i[gi];
        wb.s_tag_o = wb.m_tag_i[gi];
        wb.s_cyc_o = own & wb.m_cyc_i[gi];
        wb.s_stb_o = own & wb.m_stb_i[gi];
    end

    // A stalled cycle is a live strobe without ack; the error fires on the stall that reaches all-ones,
    // and a coincident ack suppresses it.
    assign stall   = wb.s_cyc_o & wb.s_stb_o & ~wb.s_ack_i;
    assign tmo_hit = stall && (tmo == TMO_PRE);

    // Route ack and timeout error to the owner only; read data is broadcast unconditionally.
    always_comb begin
        wb.m_dat_o = wb.s_dat_i;
        wb.m_ack_o = '0;
        wb.m_err_o = '0;
        for (int n = 0; n < AEMB_NCH; n++) begin
            wb.m_ack_o[n] = own && (gi == n) && wb.s_ack_i;
            wb.m_err_o[n] = tmo_hit && (gi == n);
        end
    end

    // Ownership FSM with grant register, round-robin pointer and stall counter.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= GW'(AEMB_NCH - 1);
            tmo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo <= '0;
                    if (win_vld) begin
                        gnt   <= win;
                        last  <= win;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (wb.s_ack_i) begin
                        tmo <= '0;
                    end else if (stall) begin
                        tmo <= tmo + 1'b1;
                    end
                    if (!wb.m_cyc_i[gi]) begin
                        state <= IDLE;
                    end else if (tmo_hit) begin
                        state <= ABORT;
                    end
                end
                ABORT: begin
                    if (!wb.m_cyc_i[gi]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aemb2_wb_arbiter.sv
// Purpose: scoreboard bench for aemb2_wb_arbiter; a round-robin and a fixed-priority instance share stimulus.
// Latency: expected events carry the absolute cycle they must appear in.
// Backpressure: slave ack is forced directly or auto-generated; contention masters drop cyc after each ack.
module tb_aemb2_wb_arbiter;
    localparam int NCH = 3;
    localparam int AWB = 32;

    localparam logic [29:0] ADR0 = 30'h040;
    localparam logic [29:0] ADR1 = 30'h100;
    localparam logic [29:0] ADR2 = 30'h2c0;
    localparam logic [31:0] DAT0 = 32'h1111_0000;
    localparam logic [31:0] DAT1 = 32'h2222_0001;
    localparam logic [31:0] DAT2 = 32'h3333_0002;
    localparam logic [3:0]  SEL0 = 4'b0001;
    localparam logic [3:0]  SEL1 = 4'b0110;
    localparam logic [3:0]  SEL2 = 4'b1000;
    localparam logic [2:0]  WRE  = 3'b010;
    localparam logic [2:0]  TAG  = 3'b100;

    localparam logic [1:0] K_GNT  = 2'd0;
    localparam logic [1:0] K_ACK  = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    localparam logic [1:0] K_DROP = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] at;
        logic [67:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [2:0]  drv_cyc, drv_stb;
    logic        ack_force, auto_ack, react;
    logic [31:0] sdat;
    logic [2:0]  drop_rr = 3'b000;
    logic [2:0]  drop_fx = 3'b000;
    logic        prev_rr = 1'b0;
    logic        prev_fx = 1'b0;

    ev_t q_rr[$];
    ev_t q_fx[$];

    aemb2_wb_arbiter_if #(.NCH(NCH), .AWB(AWB)) wb_rr ();
    aemb2_wb_arbiter_if #(.NCH(NCH), .AWB(AWB)) wb_fx ();

    aemb2_wb_arbiter #(.AEMB_NCH(NCH), .AEMB_AWB(AWB), .AEMB_ARB(1), .AEMB_TMO(4)) dut_rr (
        .sys_clk_i(clk), .sys_rst_i(rst), .wb(wb_rr)
    );
    aemb2_wb_arbiter #(.AEMB_NCH(NCH), .AEMB_AWB(AWB), .AEMB_ARB(0), .AEMB_TMO(4)) dut_fx (
        .sys_clk_i(clk), .sys_rst_i(rst), .wb(wb_fx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Contention masters release cyc for one cycle after each ack they receive.
    always @(posedge clk) begin
        drop_rr <= react ? wb_rr.m_ack_o : 3'b000;
        drop_fx <= react ? wb_fx.m_ack_o : 3'b000;
    end

    assign wb_rr.m_cyc_i = drv_cyc & ~drop_rr;
    assign wb_rr.m_stb_i = drv_stb & ~drop_rr;
    assign wb_rr.m_wre_i = WRE;
    assign wb_rr.m_tag_i = TAG;
    assign wb_rr.m_adr_i = {ADR2, ADR1, ADR0};
    assign wb_rr.m_dat_i = {DAT2, DAT1, DAT0};
    assign wb_rr.m_sel_i = {SEL2, SEL1, SEL0};
    assign wb_rr.s_dat_i = sdat;
    assign wb_rr.s_ack_i = ack_force | (auto_ack & wb_rr.s_cyc_o & wb_rr.s_stb_o);

    assign wb_fx.m_cyc_i = drv_cyc & ~drop_fx;
    assign wb_fx.m_stb_i = drv_stb & ~drop_fx;
    assign wb_fx.m_wre_i = WRE;
    assign wb_fx.m_tag_i = TAG;
    assign wb_fx.m_adr_i = {ADR2, ADR1, ADR0};
    assign wb_fx.m_dat_i = {DAT2, DAT1, DAT0};
    assign wb_fx.m_sel_i = {SEL2, SEL1, SEL0};
    assign wb_fx.s_dat_i = sdat;
    assign wb_fx.s_ack_i = ack_force | (auto_ack & wb_fx.s_cyc_o & wb_fx.s_stb_o);

    // Slave-bus image expected when channel ch is granted.
    function automatic logic [67:0] gval(input int ch);
        case (ch)
            0:       gval = {DAT0, SEL0, WRE[0], TAG[0], ADR0};
            1:       gval = {DAT1, SEL1, WRE[1], TAG[1], ADR1};
            default: gval = {DAT2, SEL2, WRE[2], TAG[2], ADR2};
        endcase
    endfunction

    // which: 1 = round-robin instance, 2 = fixed instance, 3 = both.
    task automatic expect_ev(input int which, input logic [1:0] k, input int at, input logic [67:0] v);
        ev_t e;
        e.kind = k;
        e.at   = at;
        e.val  = v;
        if (which & 1) q_rr.push_back(e);
        if (which & 2) q_fx.push_back(e);
    endtask

    task automatic got(input int d, input logic [1:0] k, input logic [67:0] v);
        ev_t e;
        n_tests++;
        if ((d == 0 && q_rr.size() == 0) || (d == 1 && q_fx.size() == 0)) begin
            n_fail++;
            $display("FAIL ev_%s unexpected: kind=%0d val=%h cycle=%0d, required none", d == 0 ? "rr" : "fx", k, v, cyc);
        end else begin
            e = (d == 0) ? q_rr.pop_front() : q_fx.pop_front();
            if (e.kind !== k || e.at !== cyc || e.val !== v) begin
                n_fail++;
                $display("FAIL ev_%s: got kind=%0d cycle=%0d val=%h, required kind=%0d cycle=%0d val=%h",
                         d == 0 ? "rr" : "fx", k, cyc, v, e.kind, e.at, e.val);
            end
        end
    endtask

    task automatic observe(input int d, input logic sc, input logic pv, input logic [67:0] gv,
                           input logic [2:0] ack, input logic [2:0] err);
        if (sc && !pv)     got(d, K_GNT, gv);
        if (ack != 3'b000) got(d, K_ACK, {65'd0, ack});
        if (err != 3'b000) got(d, K_ERR, {65'd0, err});
        if (!sc && pv)     got(d, K_DROP, 68'd0);
    endtask

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: turns DUT outputs into events and checks them against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 2) begin
                observe(0, wb_rr.s_cyc_o, prev_rr,
                        {wb_rr.s_dat_o, wb_rr.s_sel_o, wb_rr.s_wre_o, wb_rr.s_tag_o, wb_rr.s_adr_o},
                        wb_rr.m_ack_o, wb_rr.m_err_o);
                observe(1, wb_fx.s_cyc_o, prev_fx,
                        {wb_fx.s_dat_o, wb_fx.s_sel_o, wb_fx.s_wre_o, wb_fx.s_tag_o, wb_fx.s_adr_o},
                        wb_fx.m_ack_o, wb_fx.m_err_o);
                prev_rr = wb_rr.s_cyc_o;
                prev_fx = wb_fx.s_cyc_o;
            end
        end
    end

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: stimulus still running at cycle %0d, required completion", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Stimulus: directed scenarios with hand-computed event cycles.
    initial begin
        rst = 1'b1; drv_cyc = 3'b000; drv_stb = 3'b000;
        ack_force = 1'b0; auto_ack = 1'b0; react = 1'b0; sdat = 32'h0;
        step(); step();                                   // cycle 2
        drv_cyc = 3'b010; drv_stb = 3'b010; ack_force = 1'b1;
        step();                                           // cycle 3, still in reset
        @(negedge clk);
        chk("rst_scyc_rr", {67'd0, wb_rr.s_cyc_o}, 68'd0);
        chk("rst_sstb_rr", {67'd0, wb_rr.s_stb_o}, 68'd0);
        chk("rst_mack_rr", {65'd0, wb_rr.m_ack_o}, 68'd0);
        chk("rst_merr_rr", {65'd0, wb_rr.m_err_o}, 68'd0);
        chk("rst_scyc_fx", {67'd0, wb_fx.s_cyc_o}, 68'd0);
        chk("rst_mack_fx", {65'd0, wb_fx.m_ack_o}, 68'd0);
        rst = 1'b0; ack_force = 1'b0;

        // single request from ch1
        expect_ev(3, K_GNT, 4, gval(1));
        step(); step();                                   // cycle 5
        ack_force = 1'b1; sdat = 32'hdead_beef;
        expect_ev(3, K_ACK, 5, 68'b010);
        @(negedge clk);
        chk("mdat_rr", {36'd0, wb_rr.m_dat_o}, {36'd0, 32'hdead_beef});
        chk("mdat_fx", {36'd0, wb_fx.m_dat_o}, {36'd0, 32'hdead_beef});
        step();                                           // cycle 6
        ack_force = 1'b0; drv_cyc = 3'b000; drv_stb = 3'b000;
        expect_ev(3, K_DROP, 6, 68'd0);

        // burst hold: ch0 owns with stb gaps while ch2 waits
        step();                                           // cycle 7
        drv_cyc = 3'b001; drv_stb = 3'b001;
        expect_ev(3, K_GNT, 8, gval(0));
        step();                                           // cycle 8
        drv_cyc = 3'b101; drv_stb = 3'b101;
        step();                                           // cycle 9
        drv_stb = 3'b100;
        step();                                           // cycle 10
        @(negedge clk);
        chk("hold_scyc_rr", {67'd0, wb_rr.s_cyc_o}, 68'd1);
        chk("hold_sstb_rr", {67'd0, wb_rr.s_stb_o}, 68'd0);
        chk("hold_sadr_rr", {38'd0, wb_rr.s_adr_o}, {38'd0, ADR0});
        chk("hold_sadr_fx", {38'd0, wb_fx.s_adr_o}, {38'd0, ADR0});
        step(); step();                                   // cycle 12
        drv_stb = 3'b101; ack_force = 1'b1;
        expect_ev(3, K_ACK, 12, 68'b001);
        step();                                           // cycle 13
        drv_cyc = 3'b100; drv_stb = 3'b100; ack_force = 1'b0;
        expect_ev(3, K_DROP, 13, 68'd0);
        expect_ev(3, K_GNT, 15, gval(2));
        step(); step();                                   // cycle 15
        ack_force = 1'b1;
        expect_ev(3, K_ACK, 15, 68'b100);
        step();                                           // cycle 16
        ack_force = 1'b0; drv_cyc = 3'b000; drv_stb = 3'b000;
        expect_ev(3, K_DROP, 16, 68'd0);

        // timeout: ch2 stalls, error on 15th stalled cycle (32), bus drops at 33
        step();                                           // cycle 17
        drv_cyc = 3'b100; drv_stb = 3'b100;
        expect_ev(3, K_GNT, 18, gval(2));
        expect_ev(3, K_ERR, 32, 68'b100);
        expect_ev(3, K_DROP, 33, 68'd0);
        while (cyc < 34) step();
        ack_force = 1'b1;
        @(negedge clk);
        chk("abort_mack_rr", {65'd0, wb_rr.m_ack_o}, 68'd0);
        chk("abort_scyc_fx", {67'd0, wb_fx.s_cyc_o}, 68'd0);
        step();                                           // cycle 35
        ack_force = 1'b0;
        step();                                           // cycle 36
        drv_cyc = 3'b000; drv_stb = 3'b000;

        // ack exactly at terminal stall count wins over the error
        step();                                           // cycle 37
        drv_cyc = 3'b100; drv_stb = 3'b100;
        expect_ev(3, K_GNT, 38, gval(2));
        expect_ev(3, K_ACK, 52, 68'b100);
        expect_ev(3, K_DROP, 53, 68'd0);
        while (cyc < 52) step();
        ack_force = 1'b1;
        step();                                           // cycle 53
        ack_force = 1'b0; drv_cyc = 3'b000; drv_stb = 3'b000;

        // reset while ch1 owns mid-burst
        step();                                           // cycle 54
        drv_cyc = 3'b010; drv_stb = 3'b010;
        expect_ev(3, K_GNT, 55, gval(1));
        expect_ev(3, K_ACK, 56, 68'b010);
        expect_ev(3, K_DROP, 58, 68'd0);
        expect_ev(3, K_GNT, 59, gval(0));
        expect_ev(3, K_ACK, 60, 68'b001);
        expect_ev(3, K_DROP, 61, 68'd0);
        step(); step();                                   // cycle 56
        ack_force = 1'b1;
        step();                                           // cycle 57
        ack_force = 1'b0; rst = 1'b1; drv_cyc = 3'b011; drv_stb = 3'b001;
        step();                                           // cycle 58
        rst = 1'b0; drv_stb = 3'b011;
        step(); step();                                   // cycle 60
        ack_force = 1'b1;
        step();                                           // cycle 61
        ack_force = 1'b0; drv_cyc = 3'b000; drv_stb = 3'b000;

        // contention from all channels after a fresh reset
        step();                                           // cycle 62
        rst = 1'b1;
        step();                                           // cycle 63
        rst = 1'b0; drv_cyc = 3'b111; drv_stb = 3'b111; react = 1'b1; auto_ack = 1'b1;
        for (int g = 0; g < 4; g++) begin
            expect_ev(1, K_GNT, 64 + 3*g, gval(g % 3));
            expect_ev(1, K_ACK, 64 + 3*g, {65'd0, 3'b001 << (g % 3)});
            expect_ev(1, K_DROP, 65 + 3*g, 68'd0);
            expect_ev(2, K_GNT, 64 + 3*g, gval(0));
            expect_ev(2, K_ACK, 64 + 3*g, 68'b001);
            expect_ev(2, K_DROP, 65 + 3*g, 68'd0);
        end
        while (cyc < 74) step();
        drv_cyc = 3'b000; drv_stb = 3'b000; react = 1'b0; auto_ack = 1'b0;
        repeat (6) step();

        chk("leftover_rr", {36'd0, 32'(q_rr.size())}, 68'd0);
        chk("leftover_fx", {36'd0, 32'(q_fx.size())}, 68'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
